// File: rtl/blinds_position_ctrl.sv
// ---------------------------------------------------------------------------
// Module   : blinds_position_ctrl
// Brief    : Button-driven roller-blind positioner producing a 2-bit mux
//            select code, stepping the motor one quarter at a time.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module blinds_position_ctrl #(
    parameter int STEP_CYCLES = 8,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_up,
    input  logic btn_down,
    input  logic close_all,
    output logic pos_a,
    output logic pos_b,
    output logic motor_up,
    output logic motor_down,
    output logic busy
);

    localparam logic [CNT_W-1:0] c_STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [1:0]       c_POS_MAX   = 2'd3;
    localparam logic [1:0]       c_POS_MIN   = 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_t;

    state_t           r_state;
    logic [1:0]       r_pos;
    logic [1:0]       r_target;
    logic [CNT_W-1:0] r_cnt;
    logic             r_btn_up_q;
    logic             r_btn_down_q;

    logic             w_up_press;
    logic             w_down_press;
    logic [1:0]       w_target_next;
    logic             w_step_done;
    logic [1:0]       w_pos_stepped;
    state_t           w_after_step;

    assign w_up_press   = btn_up   & ~r_btn_up_q;
    assign w_down_press = btn_down & ~r_btn_down_q;

    always_comb begin
        w_target_next = r_target;
        if (close_all) begin
            w_target_next = c_POS_MIN;
        end else if (w_up_press && w_down_press) begin
            w_target_next = r_target;
        end else if (w_up_press) begin
            if (r_target != c_POS_MAX) begin
                w_target_next = r_target + 2'd1;
            end
        end else if (w_down_press) begin
            if (r_target != c_POS_MIN) begin
                w_target_next = r_target - 2'd1;
            end
        end
    end

    assign w_step_done = (r_cnt == c_STEP_LAST);

    // A move is only ever started when the target lies beyond pos, so the
    // stepped value cannot wrap outside 0..3.
    always_comb begin
        w_pos_stepped = r_pos;
        if (r_state == ST_UP) begin
            w_pos_stepped = r_pos + 2'd1;
        end else if (r_state == ST_DOWN) begin
            w_pos_stepped = r_pos - 2'd1;
        end
    end

    // Direction chosen at the end of a step compares against the new pos.
    always_comb begin
        w_after_step = ST_IDLE;
        if (r_target > w_pos_stepped) begin
            w_after_step = ST_UP;
        end else if (r_target < w_pos_stepped) begin
            w_after_step = ST_DOWN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_pos        <= 2'd0;
            r_target     <= 2'd0;
            r_cnt        <= '0;
            r_btn_up_q   <= 1'b0;
            r_btn_down_q <= 1'b0;
        end else begin
            r_btn_up_q   <= btn_up;
            r_btn_down_q <= btn_down;
            r_target     <= w_target_next;

            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (r_target > r_pos) begin
                        r_state <= ST_UP;
                    end else if (r_target < r_pos) begin
                        r_state <= ST_DOWN;
                    end
                end
                ST_UP, ST_DOWN: begin
                    if (w_step_done) begin
                        r_pos   <= w_pos_stepped;
                        r_cnt   <= '0;
                        r_state <= w_after_step;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign motor_up   = (r_state == ST_UP);
    assign motor_down = (r_state == ST_DOWN);
    assign busy       = motor_up | motor_down;
    assign pos_a      = r_pos[1];
    assign pos_b      = r_pos[0];

endmodule

`default_nettype wire

// File: tb/tb_blinds_position_ctrl.sv
// ---------------------------------------------------------------------------
// Module   : tb_blinds_position_ctrl
// Brief    : Scoreboard bench for blinds_position_ctrl against a cycle-level
//            model of target tracking and timed quarter-steps.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_blinds_position_ctrl;

    localparam int STEP = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_up, btn_down, close_all;
    logic pos_a, pos_b, motor_up, motor_down, busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [4:0] exp_q[$];

    // Reference model: target, position, travel direction and the number of
    // edges left until the running quarter-step lands.
    int m_tgt, m_pos, m_dir, m_rem;
    bit m_upq, m_dnq;

    blinds_position_ctrl #(.STEP_CYCLES(STEP), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .close_all  (close_all),
        .pos_a      (pos_a),
        .pos_b      (pos_b),
        .motor_up   (motor_up),
        .motor_down (motor_down),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] dut_out();
        return {pos_a, pos_b, motor_up, motor_down, busy};
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (pos_a,pos_b,up,down,busy) at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_tgt = 0; m_pos = 0; m_dir = 0; m_rem = 0;
        m_upq = 0; m_dnq = 0;
    endfunction

    function automatic void model_decide(input int t);
        if (t > m_pos) begin
            m_dir = 1;  m_rem = STEP;
        end else if (t < m_pos) begin
            m_dir = -1; m_rem = STEP;
        end else begin
            m_dir = 0;
        end
    endfunction

    function automatic void model_edge(input bit up, input bit dn, input bit ca);
        bit up_p = up && !m_upq;
        bit dn_p = dn && !m_dnq;
        int old_tgt = m_tgt;
        if (ca)                m_tgt = 0;
        else if (up_p && dn_p) m_tgt = m_tgt;
        else if (up_p)         m_tgt = (m_tgt < 3) ? m_tgt + 1 : 3;
        else if (dn_p)         m_tgt = (m_tgt > 0) ? m_tgt - 1 : 0;
        m_upq = up;
        m_dnq = dn;
        if (m_dir == 0) begin
            model_decide(old_tgt);
        end else begin
            m_rem--;
            if (m_rem == 0) begin
                m_pos += m_dir;
                model_decide(old_tgt);
            end
        end
    endfunction

    function automatic logic [4:0] model_out();
        logic [1:0] p = 2'(m_pos);
        return {p, m_dir == 1, m_dir == -1, m_dir != 0};
    endfunction

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) check("out", dut_out(), exp_q.pop_front());
    end

    task automatic tick(input logic up, input logic dn, input logic ca);
        @(negedge clk);
        btn_up = up; btn_down = dn; close_all = ca;
        model_edge(up, dn, ca);
        exp_q.push_back(model_out());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(btn_up, btn_down, 1'b0);
    endtask

    task automatic press_up();
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        btn_up = 0; btn_down = 0; close_all = 0;
        model_edge(1'b0, 1'b0, 1'b0);
        exp_q.push_back(model_out());
    endtask

    task automatic async_reset(input string name);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        btn_up = 0; btn_down = 0; close_all = 0;
        #1;
        check(name, dut_out(), 5'b00000);
        model_reset();
        repeat (2) @(posedge clk);
        release_reset();
    endtask

    initial begin
        logic up_l, dn_l;
        rst_n = 1'b0; btn_up = 0; btn_down = 0; close_all = 0;
        model_reset();
        #1;
        check("reset_outputs", dut_out(), 5'b00000);
        repeat (3) @(posedge clk);
        release_reset();
        idle(3);

        // Single press: one quarter-step up, then idle.
        press_up();
        idle(12);

        // Four presses saturate the target at fully open.
        repeat (4) press_up();
        idle(30);

        // Held close button is one press.
        repeat (20) tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        idle(12);

        // Return to closed, then close_all mid-step of a move towards half.
        tick(1'b0, 1'b0, 1'b1);
        idle(20);
        press_up();
        press_up();
        idle(1);
        tick(1'b0, 1'b0, 1'b1);
        idle(25);

        // Simultaneous presses at quarter are ignored.
        press_up();
        idle(12);
        repeat (20) tick(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        idle(3);

        // Async reset while travelling from half towards open.
        press_up();
        press_up();
        idle(11);
        check("pre_rst_motor_up", {4'b0, motor_up}, {4'b0, m_dir == 1});
        async_reset("async_rst_mid_step");
        idle(5);

        // Randomized button activity.
        up_l = 0; dn_l = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) up_l = ~up_l;
            if ($urandom_range(0, 6) == 0) dn_l = ~dn_l;
            tick(up_l, dn_l, $urandom_range(0, 59) == 0);
            if ($urandom_range(0, 999) == 0) async_reset("async_rst_random");
        end
        idle(40);

        repeat (2) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, 0 required", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/blinds_position_ctrl.md
Name: blinds_position_ctrl

Overview:
- Upstream stage of the roller-blind output mux. Turns user up/down button presses into a 2-bit blind position code {pos_a, pos_b}. The downstream mux uses this code as its select inputs (a, b).
- Position codes: 0 closed, 1 quarter, 2 half, 3 fully open.
- Holds a target position set by the buttons. Drives the motor up or down one quarter-step at a time until the reported position equals the target.
- Each quarter-step takes a fixed number of clock cycles.

Parameters:
- STEP_CYCLES, 8: clock cycles of motor travel per quarter-step. Legal range is 2..255.
- CNT_W, 8: width of the step counter. Must satisfy 2^CNT_W > STEP_CYCLES-1.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- btn_up  input  1  open button, synchronous level; rising edge = one press.
- btn_down  input  1  close button, synchronous level; rising edge = one press.
- close_all  input  1  synchronous level; while high, forces target to 0.
- pos_a  output  1  position code MSB; drives the mux input a.
- pos_b  output  1  position code LSB; drives the mux input b.
- motor_up  output  1  motor driving towards open.
- motor_down  output  1  motor driving towards closed.
- busy  output  1  high whenever motor_up or motor_down is high.

Behaviour:
- Reset (rst_n low, asynchronous) clears:
  - pos = 0 and target = 0;
  - state = IDLE and cnt = 0;
  - btn_up_q = 0 and btn_down_q = 0.
- During reset all outputs are 0.
- Reset asserted mid-move drops the motor outputs immediately; pos returns to 0 (closed).
- Edge detect:
  - up_press = btn_up & ~btn_up_q; down_press = btn_down & ~btn_down_q.
  - btn_up_q and btn_down_q are registered every cycle.
  - Holding a button produces exactly one press.
- Target update on each clock edge, in priority order:
  - close_all high -> target = 0;
  - else up_press and down_press together -> target unchanged (both ignored);
  - else up_press -> target + 1, saturating at 3;
  - else down_press -> target - 1, saturating at 0.
- State machine: IDLE, UP, DOWN.
- IDLE:
  - target > pos -> UP, cnt = 0;
  - target < pos -> DOWN, cnt = 0;
  - otherwise stay in IDLE.
- UP and DOWN:
  - cnt increments every cycle.
  - When cnt == STEP_CYCLES-1, pos moves by ±1 and cnt = 0.
  - On that same edge the FSM re-evaluates against the target, comparing with the new pos. It continues in the same direction, reverses directly to the other direction, or returns to IDLE.
- A target change mid-step never aborts the step in progress. The step always completes before the direction is re-evaluated.
- Target comparisons in IDLE use the registered target value, i.e. the value from the previous edge.
- Latency:
  - Press sampled at edge E0 -> target updated at E0.
  - State leaves IDLE at E1.
  - pos changes at E0 + STEP_CYCLES + 1.
  - Each further step adds STEP_CYCLES cycles.
- Output decode, all from registers with no combinational path from inputs:
  - motor_up = (state == UP); motor_down = (state == DOWN);
  - busy = motor_up | motor_down.
- pos_a = pos[1]; pos_b = pos[0].
- pos never leaves the range 0..3, and pos never changes while in IDLE.
- motor_up and motor_down are never high simultaneously.

Test Plan:
- Reset, then one btn_up pulse with STEP_CYCLES=8:
  - target = 1 at the press edge; motor_up high from the next edge.
  - {pos_a,pos_b} = 01 exactly 9 edges after the press edge.
  - Back to IDLE with busy = 0 on that same edge.
- Four btn_up presses while idle:
  - target saturates at 3; three consecutive steps with motor_up held high throughout.
  - pos = 3 after 1 + 3×8 cycles, then IDLE.
- At pos = 3, btn_down held high for 20 cycles:
  - counts as a single press; target = 2.
  - One DOWN step; pos = 2 after 9 cycles.
- While moving UP from 0 towards 2, close_all pulsed at cnt = 3:
  - the current step finishes (pos = 1).
  - The FSM goes directly UP -> DOWN on that same edge; motor_up is never high together with motor_down.
  - pos = 0 after a further 8 cycles.
- btn_up and btn_down rising on the same cycle while idle at pos = 1:
  - target stays 1; no motor activity for 20 cycles.
- rst_n pulsed low mid-step at pos = 2 heading to 3:
  - motor_up falls asynchronously before the next clock edge.
  - After release, pos = 0, target = 0, state IDLE.
